program_counter: RTL and testbench

- Holds the instruction fetch address of the RISC-V core.
- Advances the address by one instruction (4 bytes) on each enabled rising clock edge.
- Supports a redirect load (branch, jump or trap target), a stall/hold, and an asynchronous reset to a fixed boot address.
- Sits at the head of the fetch path and drives the instruction-memory address.

---
 rtl/program_counter_pkg.sv | 21 ++
 rtl/program_counter_if.sv | 22 ++
 rtl/program_counter_pc_adder.sv | 15 +
 rtl/program_counter.sv | 70 +++++++
 tb/tb_program_counter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/program_counter_pkg.sv
// Shared constants and types for the instruction fetch program counter.
package program_counter_pkg;

  localparam int unsigned PC_WORDSIZE   = 64;
  localparam logic [63:0] PC_RESET_ADDR = 64'h0;
  localparam int unsigned INSTR_BYTES   = 4;

  // Kind of register update selected on a clock edge, in priority order.
  typedef enum logic [1:0] {
    UPD_HOLD   = 2'd0,
    UPD_LOAD   = 2'd1,
    UPD_REJECT = 2'd2,
    UPD_STEP   = 2'd3
  } pc_upd_e;

  // A fetch address is usable only if it lands on an instruction boundary.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/program_counter_if.sv
// Fetch-control bundle between the core front end and the program counter.
interface program_counter_if
  #(parameter int unsigned WORDSIZE = program_counter_pkg::PC_WORDSIZE);

  logic                en;
  logic                load;
  logic [WORDSIZE-1:0] load_addr;
  logic [WORDSIZE-1:0] addr;
  logic [WORDSIZE-1:0] next_addr;
  logic                misalign;

  modport master (
    output en, load, load_addr,
    input  addr, next_addr, misalign
  );

  modport slave (
    input  en, load, load_addr,
    output addr, next_addr, misalign
  );

endinterface

// File: rtl/program_counter_pc_adder.sv
// Sequential-step adder: current PC plus a fixed stride, modulo 2^WORDSIZE.
module pc_adder
  import program_counter_pkg::*;
#(
  parameter int unsigned WORDSIZE  = PC_WORDSIZE,
  parameter int unsigned INCREMENT = INSTR_BYTES
) (
  input  logic [WORDSIZE-1:0] a,
  output logic [WORDSIZE-1:0] sum_c
);

  // Carry out of the top bit is dropped so the PC wraps silently.
  assign sum_c = a + WORDSIZE'(INCREMENT);

endmodule

// File: rtl/program_counter.sv
// Instruction fetch address register with stall, redirect and misalign flag.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned         WORDSIZE   = PC_WORDSIZE,
  parameter logic [WORDSIZE-1:0] RESET_ADDR = WORDSIZE'(PC_RESET_ADDR),
  parameter int unsigned         INCREMENT  = INSTR_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  program_counter_if.slave  pc
);

  logic [WORDSIZE-1:0] addr_q;
  logic [WORDSIZE-1:0] inc_c;
  logic                misalign_q;
  pc_upd_e             upd_c;

  pc_adder #(
    .WORDSIZE  (WORDSIZE),
    .INCREMENT (INCREMENT)
  ) u_pc_adder (
    .a     (addr_q),
    .sum_c (inc_c)
  );

  // Pick the update for this edge: stall beats redirect beats sequential step.
  always_comb begin
    upd_c = UPD_HOLD;
    if (pc.en) begin
      if (pc.load) begin
        upd_c = is_aligned(pc.load_addr[1:0]) ? UPD_LOAD : UPD_REJECT;
      end else begin
        upd_c = UPD_STEP;
      end
    end
  end

  // PC and misalign flag; a rejected target leaves the PC where it is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= RESET_ADDR;
      misalign_q <= 1'b0;
    end else begin
      case (upd_c)
        UPD_HOLD: begin
          addr_q     <= addr_q;
          misalign_q <= misalign_q;
        end
        UPD_LOAD: begin
          addr_q     <= pc.load_addr;
          misalign_q <= 1'b0;
        end
        UPD_REJECT: begin
          addr_q     <= addr_q;
          misalign_q <= 1'b1;
        end
        UPD_STEP: begin
          addr_q     <= inc_c;
          misalign_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc.addr      = addr_q;
  assign pc.next_addr = inc_c;
  assign pc.misalign  = misalign_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed fetch scenarios plus random traffic.
module tb_program_counter;

  localparam logic [63:0] RST_ADDR = 64'h0;

  typedef struct packed {
    logic [63:0] addr;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  exp_t        exp_q[$];
  logic [63:0] m_pc  = RST_ADDR;
  logic        m_mis = 1'b0;

  program_counter_if #(.WORDSIZE(64)) pc_if ();

  program_counter #(
    .WORDSIZE   (64),
    .RESET_ADDR (RST_ADDR),
    .INCREMENT  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pc    (pc_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the reference, queue the expected result.
  task automatic cycle(input logic e, input logic l, input logic [63:0] la);
    exp_t x;
    pc_if.en        = e;
    pc_if.load      = l;
    pc_if.load_addr = la;
    if (!rst_n) begin
      m_pc  = RST_ADDR;
      m_mis = 1'b0;
    end else if (e) begin
      if (l) begin
        if (la % 64'd4 == 64'd0) begin
          m_pc  = la;
          m_mis = 1'b0;
        end else begin
          m_mis = 1'b1;
        end
      end else begin
        m_pc  = m_pc + 64'd4;
        m_mis = 1'b0;
      end
    end
    x.addr = m_pc;
    x.mis  = m_mis;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("addr", pc_if.addr, x.addr);
        check("next_addr", pc_if.next_addr, x.addr + 64'd4);
        check("misalign", 64'(pc_if.misalign), 64'(x.mis));
      end
    end
  end

  initial begin
    logic [63:0] la;
    logic        e, l;
    int          kind;

    pc_if.en        = 1'b0;
    pc_if.load      = 1'b0;
    pc_if.load_addr = '0;

    // Reset state before any clock edge has been accepted.
    @(negedge clk);
    check("reset_addr", pc_if.addr, RST_ADDR);
    check("reset_next", pc_if.next_addr, RST_ADDR + 64'd4);
    check("reset_mis", 64'(pc_if.misalign), 64'd0);
    rst_n = 1'b1;

    // Sequential steps 0x4 .. 0x14.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0);

    // Back to 0, step to 0x8, stall three clocks, then resume.
    rst_n = 1'b0;
    #1;
    m_pc = RST_ADDR;
    m_mis = 1'b0;
    check("rst_pulse_addr", pc_if.addr, RST_ADDR);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);

    // Aligned redirect from 0x10, then a step.
    cycle(1'b1, 1'b1, 64'h0000_0000_8000_0000);
    cycle(1'b1, 1'b0, '0);

    // Misaligned redirect is rejected; stall keeps the flag; a step clears it.
    cycle(1'b1, 1'b1, 64'h0000_0000_0000_1002);
    cycle(1'b0, 1'b1, 64'h0000_0000_0000_2000);
    cycle(1'b1, 1'b0, '0);

    // Wrap-around at the top of the address space.
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b1, 1'b0, '0);

    // Asynchronous reset between edges while a redirect and a misalign flag are pending.
    cycle(1'b1, 1'b1, 64'h0000_0000_0000_0403);
    pc_if.en        = 1'b1;
    pc_if.load      = 1'b1;
    pc_if.load_addr = 64'h0000_0000_0000_2000;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_addr", pc_if.addr, RST_ADDR);
    check("async_rst_mis", 64'(pc_if.misalign), 64'd0);
    m_pc  = RST_ADDR;
    m_mis = 1'b0;
    @(negedge clk);
    cycle(1'b1, 1'b1, 64'h0000_0000_0000_2000);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);

    // Random traffic: stalls, redirects of every alignment, runs near the wrap point.
    for (int n = 0; n < 400; n++) begin
      e    = ($urandom_range(0, 9) != 0);
      l    = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       la = {$urandom, $urandom};
        1:       la = {$urandom, $urandom} & ~64'h3;
        2:       la = 64'hFFFF_FFFF_FFFF_FFE0 + 64'(4 * $urandom_range(0, 7));
        default: la = 64'($urandom_range(0, 255)) << 2;
      endcase
      cycle(e, l, la);
    end

    pc_if.en = 1'b0;
    pc_if.load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
